// File: rtl/mem_access_unit.sv
// Load/store unit between the M stage and a ready/valid data memory: IDLE -> REQ -> DONE handshake.
// Optional build macro MISALIGN_TRAP_EN: flag misaligned accesses instead of aligning them down.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,

    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,

    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] rdata_q, rdata_d;

    logic        access;
    logic        aligned;
    logic        start;
    logic        is_byte;
    logic        is_half;
    logic [31:0] eff_addr;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] lane_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    // funct3[1:0] gives the access width for both loads and stores; 11 falls back to word.
    always_comb begin
        access  = MemReadM | MemWriteM;
        is_byte = (funct3M[1:0] == 2'b00);
        is_half = (funct3M[1:0] == 2'b01);
    end

`ifdef MISALIGN_TRAP_EN
    logic nat_aligned;

    always_comb begin
        nat_aligned = is_byte
                    | (is_half & ~ALUResultM[0])
                    | (~is_byte & ~is_half & (ALUResultM[1:0] == 2'b00));
        aligned     = nat_aligned;
        MisalignM   = (state_q == StIdle) & access & ~nat_aligned;
    end
`else
    always_comb begin
        aligned   = 1'b1;
        MisalignM = 1'b0;
    end
`endif

    // Aligning down is a no-op for naturally aligned addresses, so it is applied unconditionally.
    always_comb begin
        if (is_byte) begin
            eff_addr = ALUResultM;
        end else if (is_half) begin
            eff_addr = {ALUResultM[31:1], 1'b0};
        end else begin
            eff_addr = {ALUResultM[31:2], 2'b00};
        end
    end

    always_comb begin
        if (is_byte) begin
            be_n    = 4'b0001 << eff_addr[1:0];
            wdata_n = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            be_n    = eff_addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{WriteDataM[15:0]}};
        end else begin
            be_n    = 4'b1111;
            wdata_n = WriteDataM;
        end
    end

    always_comb begin
        lane_word = dmem_rdata >> {addr_q[1:0], 3'b000};
        lane_byte = lane_word[7:0];
        lane_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'h000000, lane_byte};
            3'b101:  load_ext = {16'h0000, lane_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        start = (state_q == StIdle) & access & aligned;
        StallM = start | (state_q == StReq);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StReq;
                    addr_d   = eff_addr;
                    we_d     = MemWriteM;
                    be_d     = be_n;
                    wdata_d  = wdata_n;
                    funct3_d = funct3M;
                end
            end
            StReq: begin
                if (dmem_ready) begin
                    state_d = StDone;
                    if (!we_q) begin
                        rdata_d = load_ext;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
        end
    end

    // Memory-side outputs come straight from registers so they stay stable across wait states.
    always_comb begin
        dmem_req   = (state_q == StReq);
        dmem_we    = dmem_req & we_q;
        dmem_addr  = {addr_q[31:2], 2'b00};
        dmem_wdata = wdata_q;
        dmem_be    = dmem_req ? be_q : 4'h0;
        ReadDataM  = rdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
// Honours MISALIGN_TRAP_EN when the same macro is defined for the build.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM;

`ifdef MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs for the current cycle, written by the driver.
    bit          chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_mis;
    logic [31:0] exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    int          stall_cnt = 0;
    logic        mis_seen = 1'b0;
    logic [3:0]  last_be = 4'h0;
    logic [31:0] last_wdata = 32'h0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("StallM", 32'(StallM), 32'(exp_stall));
            check("dmem_req", 32'(dmem_req), 32'(exp_req));
            check("dmem_we", 32'(dmem_we), 32'(exp_we));
            check("MisalignM", 32'(MisalignM), 32'(exp_mis));
            check("ReadDataM", ReadDataM, exp_rd);
            if (exp_req) begin
                check("dmem_addr", dmem_addr, exp_addr);
                if (exp_we) begin
                    check("dmem_wdata", dmem_wdata, exp_wdata);
                    check("dmem_be", 32'(dmem_be), 32'(exp_be));
                end
            end
        end
        if (StallM) stall_cnt++;
        if (MisalignM) mis_seen = 1'b1;
        if (dmem_req) begin
            last_be = dmem_be;
            last_wdata = dmem_wdata;
        end
    end

    function automatic int unsigned acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] word,
                                             input logic [1:0] off);
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] h;
        s = word >> (8 * off);
        b = s & 32'hFF;
        h = s & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    // One M-stage instruction, held until the unit releases the stall.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          input logic [31:0] rword);
        int unsigned sz;
        logic [31:0] ea;
        bit acc, mis, go;
        logic [1:0] off;
        sz  = acc_size(f3);
        ea  = a & ~(sz - 1);
        off = ea[1:0];
        acc = rd | wr;
        mis = (a % sz) != 0;
        go  = acc && !(Trap && mis);
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
        dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        exp_stall = go; exp_req = 1'b0; exp_we = 1'b0; exp_mis = Trap && acc && mis;
        @(posedge clk); #1;
        if (go) begin
            exp_mis = 1'b0; exp_stall = 1'b1; exp_req = 1'b1; exp_we = wr;
            exp_addr = ea & 32'hFFFFFFFC;
            case (sz)
                1: begin exp_wdata = (wd & 32'hFF) * 32'h01010101; exp_be = 4'b0001 << off; end
                2: begin exp_wdata = (wd & 32'hFFFF) * 32'h00010001;
                         exp_be = (off >= 2) ? 4'b1100 : 4'b0011; end
                default: begin exp_wdata = wd; exp_be = 4'b1111; end
            endcase
            for (int w = 0; w <= waits; w++) begin
                dmem_ready = (w == waits);
                dmem_rdata = (w == waits) ? rword : $urandom;
                @(posedge clk); #1;
            end
            exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0;
            if (rd && !wr) exp_rd = load_val(f3, rword, off);
            dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
            @(posedge clk); #1;
        end
        MemReadM = 1'b0; MemWriteM = 1'b0; exp_mis = 1'b0; exp_stall = 1'b0;
    endtask

    logic [2:0]  load_f3s [8];
    logic [31:0] prev_rd;

    initial begin
        load_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        reset = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'd0; ALUResultM = 32'h0; WriteDataM = 32'h0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_rd = 32'h0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("reset dmem_be", 32'(dmem_be), 32'h0);

        stall_cnt = 0;
        run_op(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        check("LW 0x100 ReadDataM", ReadDataM, 32'hDEADBEEF);
        check("LW 0x100 stall cycles", 32'(stall_cnt), 32'd2);

        run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 1, 32'h80112233);
        check("LB 0x103 ReadDataM", ReadDataM, 32'hFFFFFF80);
        run_op(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h80112233);
        check("LBU 0x103 ReadDataM", ReadDataM, 32'h00000080);

        stall_cnt = 0;
        run_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 3, 32'h0);
        check("SH 0x202 stall cycles", 32'(stall_cnt), 32'd5);
        check("SH 0x202 be", 32'(last_be), 32'hC);
        check("SH 0x202 wdata", last_wdata, 32'hABCDABCD);
        check("SH 0x202 ReadDataM held", ReadDataM, 32'h00000080);

        stall_cnt = 0; mis_seen = 1'b0; prev_rd = exp_rd;
        run_op(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h12345678);
        check("LW 0x101 MisalignM", 32'(mis_seen), 32'(Trap));
        check("LW 0x101 stall cycles", 32'(stall_cnt), Trap ? 32'd0 : 32'd2);
        check("LW 0x101 ReadDataM", ReadDataM, Trap ? prev_rd : 32'h12345678);

        run_op(1'b1, 1'b1, 3'd2, 32'h400, 32'h55AA55AA, 1, 32'h0BADF00D);
        check("LD+ST ReadDataM held", ReadDataM, prev_rd ^ (Trap ? 32'h0 : prev_rd ^ 32'h12345678));

        for (int i = 0; i < 300; i++) begin
            int k;
            logic rd, wr;
            logic [2:0] f3;
            k  = $urandom_range(0, 9);
            rd = (k < 5);
            wr = (k >= 4) && (k < 9);
            f3 = wr ? 3'($urandom_range(0, 2)) : load_f3s[$urandom_range(0, 7)];
            run_op(rd, wr, f3, $urandom, $urandom, $urandom_range(0, 3), $urandom);
        end

        run_op(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, 0, 32'hCAFEF00D);
        check("pre-reset ReadDataM", ReadDataM, 32'hCAFEF00D);
        // Abandon a load mid-handshake with an asynchronous reset.
        MemReadM = 1'b1; funct3M = 3'd2; ALUResultM = 32'h300; dmem_ready = 1'b0;
        exp_stall = 1'b1;
        @(posedge clk); #1;
        exp_req = 1'b1; exp_addr = 32'h300;
        @(posedge clk); #1;
        chk_en = 1'b0;
        MemReadM = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset in REQ dmem_req", 32'(dmem_req), 32'h0);
        check("reset in REQ dmem_we", 32'(dmem_we), 32'h0);
        check("reset in REQ dmem_be", 32'(dmem_be), 32'h0);
        check("reset in REQ ReadDataM", ReadDataM, 32'h0);
        check("reset in REQ StallM", 32'(StallM), 32'h0);
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_rd = 32'h0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b1;
        dmem_ready = 1'b1; dmem_rdata = 32'hFEEDFACE;
        repeat (3) begin
            @(posedge clk); #1;
        end
        dmem_ready = 1'b0;
        check("ready after reset ignored", ReadDataM, 32'h0);
        run_op(1'b1, 1'b0, 3'd5, 32'h302, 32'h0, 2, 32'h9ABC1234);
        check("LHU 0x302 ReadDataM", ReadDataM, 32'h00009ABC);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; reset=0 clears all state.
REQ-003 SHALL have inputs from E/M stage:
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- funct3M  in  3  access size/sign
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data
REQ-004 SHALL have data-memory ports:
- dmem_req  out  1  request valid
- dmem_we  out  1  1=write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-aligned store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  request accepted/completed
- dmem_rdata  in  32  read word, valid with dmem_ready
REQ-005 SHALL have pipeline outputs:
- ReadDataM  out  32  extended load result to M/W register
- StallM  out  1  hold F/D/E/M registers and block M/W update
- MisalignM  out  1  misaligned access flag

Function
REQ-006 SHALL implement FSM IDLE, REQ, DONE; reset state IDLE.
REQ-007 IDLE: access = MemReadM|MemWriteM; if access and aligned -> REQ next edge, latching address, we, be, wdata, funct3, addr[1:0] into internal registers.
REQ-008 REQ: dmem_req=1 with all dmem_* outputs stable from registers; on dmem_ready=1 -> DONE (capture extended load data if read); else stay REQ.
REQ-009 DONE: dmem_req=0, StallM=0, unconditionally -> IDLE next edge.
REQ-010 StallM = (IDLE & access & aligned) | REQ; combinational.
REQ-011 Minimum memory-op latency 3 cycles: StallM high in cycles 0 and 1, low in cycle 2 (DONE) when ready arrives in cycle 1; each extra wait cycle adds one stall cycle.
REQ-012 dmem_addr = {addr[31:2],2'b00}; dmem_req=0 and dmem_we=0 outside REQ.
REQ-013 Stores:
- SB (000): be=1<<addr[1:0], wdata = byte replicated x4
- SH (001): be=0011 (addr[1]=0) / 1100 (addr[1]=1), wdata = half replicated x2
- SW (010): be=1111
REQ-014 Loads select lane by addr[1:0]: LB 000 sign-ext, LH 001 sign-ext, LW 010, LBU 100 zero-ext, LHU 101 zero-ext; other funct3 -> word as LW.
REQ-015 ReadDataM SHALL be registered, updated only at REQ->DONE for reads, otherwise hold.
REQ-016 MemReadM and MemWriteM both high: treated as store; ReadDataM unchanged.
REQ-017 Aligned: byte always; half addr[0]=0; word addr[1:0]=00.
REQ-018 dmem_ready outside REQ SHALL be ignored.

Reset
REQ-019 reset=0 SHALL immediately force IDLE, dmem_req=0, dmem_we=0, dmem_be=0, ReadDataM=0, latched regs 0; StallM, MisalignM then follow inputs combinationally.
REQ-020 Reset asserted in REQ SHALL abandon the access; no capture on release.

Configuration
REQ-021 Macro MISALIGN_TRAP_EN defined: misaligned access SHALL assert MisalignM (combinational, IDLE only), issue no request, StallM=0, ReadDataM unchanged.
REQ-022 MISALIGN_TRAP_EN undefined: MisalignM tied 0; misaligned half/word SHALL force low address bits to zero (align down) and execute as aligned.

Verification
REQ-023 LW addr 0x100, dmem_ready in first REQ cycle, rdata 0xDEADBEEF -> dmem_addr 0x100, StallM 2 cycles, ReadDataM=0xDEADBEEF in DONE.
REQ-024 LB addr 0x103, rdata 0x80112233 -> ReadDataM=0xFFFFFF80; LBU same -> 0x00000080.
REQ-025 SH addr 0x202, WriteDataM 0x0000ABCD, ready after 3 wait cycles -> be=1100, wdata=0xABCDABCD, dmem_we=1, StallM 5 cycles total.
REQ-026 LW addr 0x101 with MISALIGN_TRAP_EN -> MisalignM=1, dmem_req stays 0, StallM=0; without macro -> dmem_addr 0x100, normal load.
REQ-027 Reset pulse while in REQ with dmem_ready=0 -> dmem_req=0 same cycle, IDLE, ReadDataM=0; later ready pulse ignored.
